// File: rtl/si5338_iic_pkg.sv
// Shared definitions for the Si5338 I2C target model and its benches.
package si5338_iic_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_PTR,
        S_PTR_ACK,
        S_WDATA,
        S_WDATA_ACK,
        S_RDATA,
        S_RDATA_MACK,
        S_IGNORE
    } iic_state_t;

    // Level seen on SDA in the acknowledge slot
    localparam logic IIC_ACK  = 1'b0;
    localparam logic IIC_NACK = 1'b1;

    // 7-bit bus address of the Si5338
    localparam logic [6:0] SI5338_I2C_ADDR = 7'b111_0000;

endpackage

// File: rtl/iic_line_sync.sv
// Two-flop synchronizer for one open-drain I2C line, with edge detect
// on the synchronized value.
module iic_line_sync (
    input  logic CLK,
    input  logic RST,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Synchronize the line and keep the previous sample; idle bus level is high
    always_ff @(posedge CLK) begin
        if (RST) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level = sync_q;
    assign rise  = sync_q & ~prev_q;
    assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/si5338_iic_slave_model.sv
// I2C target model answering at the Si5338 address, backed by a small
// register file; register writes are echoed on a strobe port.
module si5338_iic_slave_model
    import si5338_iic_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR = SI5338_I2C_ADDR,
    parameter int unsigned REG_DEPTH  = 16,
    parameter logic [7:0]  RD_DEFAULT = 8'hFF
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SCL,
    inout  wire        SDA,
    output logic       reg_wr_stb,
    output logic [7:0] reg_wr_addr,
    output logic [7:0] reg_wr_data,
    output logic       busy
);

    localparam int unsigned AW = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    iic_line_sync u_scl_sync (
        .CLK   (CLK),
        .RST   (RST),
        .din   (SCL),
        .level (scl_lvl),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    iic_line_sync u_sda_sync (
        .CLK   (CLK),
        .RST   (RST),
        .din   (SDA),
        .level (sda_lvl),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    iic_state_t state_q, state_d;
    logic [7:0] shreg_q, shreg_d;
    logic [3:0] bitcnt_q, bitcnt_d;
    logic [7:0] ptr_q, ptr_d;
    logic       rw_q, rw_d;
    logic       sda_low_q, sda_low_d;
    logic       busy_q, busy_d;
    logic       stb_q, stb_d;
    logic [7:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       rf_we;
    logic [7:0] regs [REG_DEPTH];

    // SCL must be steadily high; an SCL edge in the same sample makes it a data change
    logic start_det, stop_det;
    assign start_det = sda_fall & scl_lvl & ~scl_rise;
    assign stop_det  = sda_rise & scl_lvl & ~scl_rise;

    logic [7:0] byte_in;
    logic       ptr_in_range;
    logic [7:0] rd_byte;
    assign byte_in      = {shreg_q[6:0], sda_lvl};
    assign ptr_in_range = ({24'b0, ptr_q} < REG_DEPTH);
    assign rd_byte      = ptr_in_range ? regs[ptr_q[AW-1:0]] : RD_DEFAULT;

    // Next-state and datapath decode for the bus protocol
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bitcnt_d  = bitcnt_q;
        ptr_d     = ptr_q;
        rw_d      = rw_q;
        sda_low_d = sda_low_q;
        busy_d    = busy_q;
        stb_d     = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        rf_we     = 1'b0;

        if (start_det) begin
            state_d   = S_ADDR;
            shreg_d   = '0;
            bitcnt_d  = '0;
            sda_low_d = 1'b0;
        end else if (stop_det) begin
            state_d   = S_IDLE;
            bitcnt_d  = '0;
            sda_low_d = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                S_ADDR, S_PTR, S_WDATA: begin
                    if (scl_rise) begin
                        shreg_d  = byte_in;
                        bitcnt_d = bitcnt_q + 4'd1;
                        if (bitcnt_q == 4'd7) begin
                            if (state_q == S_ADDR) begin
                                if (byte_in[7:1] == SLAVE_ADDR) begin
                                    state_d = S_ADDR_ACK;
                                    rw_d    = byte_in[0];
                                    busy_d  = 1'b1;
                                end else begin
                                    state_d = S_IGNORE;
                                end
                            end else if (state_q == S_PTR) begin
                                ptr_d   = byte_in;
                                state_d = S_PTR_ACK;
                            end else begin
                                if (ptr_in_range) begin
                                    rf_we     = 1'b1;
                                    stb_d     = 1'b1;
                                    wr_addr_d = ptr_q;
                                    wr_data_d = byte_in;
                                end
                                ptr_d   = ptr_q + 8'd1;
                                state_d = S_WDATA_ACK;
                            end
                        end
                    end
                end

                // First SCL fall drives the ACK, the second releases it
                S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!sda_low_q) begin
                            sda_low_d = (IIC_ACK == 1'b0);
                        end else begin
                            sda_low_d = 1'b0;
                            bitcnt_d  = '0;
                            if (state_q == S_ADDR_ACK && rw_q) begin
                                shreg_d   = rd_byte;
                                sda_low_d = ~rd_byte[7];
                                state_d   = S_RDATA;
                            end else if (state_q == S_ADDR_ACK) begin
                                state_d = S_PTR;
                            end else begin
                                state_d = S_WDATA;
                            end
                        end
                    end
                end

                S_RDATA: begin
                    if (scl_rise) begin
                        bitcnt_d = bitcnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bitcnt_q == 4'd8) begin
                            sda_low_d = 1'b0;
                            state_d   = S_RDATA_MACK;
                        end else begin
                            shreg_d   = {shreg_q[6:0], 1'b0};
                            sda_low_d = ~shreg_q[6];
                        end
                    end
                end

                // bitcnt 9 marks a master ACK awaiting the fall that starts the next byte
                S_RDATA_MACK: begin
                    if (scl_rise) begin
                        if (sda_lvl == IIC_ACK) begin
                            ptr_d    = ptr_q + 8'd1;
                            bitcnt_d = 4'd9;
                        end else begin
                            state_d = S_IGNORE;
                        end
                    end else if (scl_fall && bitcnt_q == 4'd9) begin
                        shreg_d   = rd_byte;
                        sda_low_d = ~rd_byte[7];
                        bitcnt_d  = '0;
                        state_d   = S_RDATA;
                    end
                end

                default: ;
            endcase
        end
    end

    // Protocol state, pointer and output registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            shreg_q   <= '0;
            bitcnt_q  <= '0;
            ptr_q     <= '0;
            rw_q      <= 1'b0;
            sda_low_q <= 1'b0;
            busy_q    <= 1'b0;
            stb_q     <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bitcnt_q  <= bitcnt_d;
            ptr_q     <= ptr_d;
            rw_q      <= rw_d;
            sda_low_q <= sda_low_d;
            busy_q    <= busy_d;
            stb_q     <= stb_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Register file storage
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned i = 0; i < REG_DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (rf_we) begin
            regs[ptr_q[AW-1:0]] <= byte_in;
        end
    end

    assign SDA         = sda_low_q ? 1'b0 : 1'bz;
    assign reg_wr_stb  = stb_q;
    assign reg_wr_addr = wr_addr_q;
    assign reg_wr_data = wr_data_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_si5338_iic_slave_model.sv
// Bench for the Si5338 I2C target model: a bit-banged master drives the
// bus; register-write strobes are checked against a scoreboard queue.
module tb_si5338_iic_slave_model;
    import si5338_iic_pkg::*;

    localparam int TQ = 250;   // quarter SCL period, CLK period is 20

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       m_scl = 1'b1;
    logic       m_sda_low = 1'b0;
    wire        sda_bus;
    logic       reg_wr_stb;
    logic [7:0] reg_wr_addr;
    logic [7:0] reg_wr_data;
    logic       busy;

    pullup (sda_bus);
    assign sda_bus = m_sda_low ? 1'b0 : 1'bz;

    si5338_iic_slave_model #(
        .SLAVE_ADDR (7'h70),
        .REG_DEPTH  (16),
        .RD_DEFAULT (8'hFF)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .SCL         (m_scl),
        .SDA         (sda_bus),
        .reg_wr_stb  (reg_wr_stb),
        .reg_wr_addr (reg_wr_addr),
        .reg_wr_data (reg_wr_data),
        .busy        (busy)
    );

    always #10 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;
    wr_t exp_q[$];
    wr_t mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [7:0] a, input logic [7:0] d);
        exp_q.push_back(wr_t'({a, d}));
    endtask

    // Strobe monitor: every pulse must match the oldest expected write
    always @(negedge CLK) begin
        if (!RST && reg_wr_stb) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL wr_stb: got addr 0x%0h data 0x%0h, expected no write", reg_wr_addr, reg_wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                if ({reg_wr_addr, reg_wr_data} !== mon_e) begin
                    n_err++;
                    $display("FAIL wr_stb: got addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h",
                             reg_wr_addr, reg_wr_data, mon_e.a, mon_e.d);
                end
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "timeout");
    end

    task automatic i2c_start();
        m_sda_low = 1'b0; #TQ;
        m_scl = 1'b1;     #TQ;
        m_sda_low = 1'b1; #TQ;
        m_scl = 1'b0;     #TQ;
    endtask

    task automatic i2c_stop();
        m_sda_low = 1'b1; #TQ;
        m_scl = 1'b1;     #TQ;
        m_sda_low = 1'b0; #TQ;
    endtask

    task automatic write_bit(input logic b);
        m_sda_low = ~b; #TQ;
        m_scl = 1'b1;   #TQ;
        #TQ;
        m_scl = 1'b0;   #TQ;
    endtask

    task automatic read_bit(output logic b);
        m_sda_low = 1'b0; #TQ;
        m_scl = 1'b1;     #TQ;
        b = sda_bus;      #TQ;
        m_scl = 1'b0;     #TQ;
    endtask

    // Returns 1 when the target acknowledged
    task automatic wbyte(input logic [7:0] v, output logic acked);
        logic b;
        for (int i = 7; i >= 0; i--) write_bit(v[i]);
        read_bit(b);
        acked = (b == IIC_ACK);
    endtask

    task automatic rbyte(output logic [7:0] v, input logic m_ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            v[i] = b;
        end
        write_bit(m_ack ? IIC_ACK : IIC_NACK);
    endtask

    logic       ack;
    logic [7:0] rd;

    initial begin
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        chk("rst sda", sda_bus, 1'b1);
        chk("rst stb", reg_wr_stb, 1'b0);
        chk("rst addr", reg_wr_addr, 8'h00);
        chk("rst data", reg_wr_data, 8'h00);
        chk("rst busy", busy, 1'b0);
        RST = 1'b0;
        repeat (5) @(negedge CLK);

        // Single write: ptr 0x03, data 0xA5
        i2c_start();
        wbyte(8'hE0, ack); chk("t1 addr ack", ack, 1'b1);
        wbyte(8'h03, ack); chk("t1 ptr ack", ack, 1'b1);
        expect_wr(8'h03, 8'hA5);
        wbyte(8'hA5, ack); chk("t1 data ack", ack, 1'b1);
        chk("t1 busy", busy, 1'b1);
        i2c_stop();
        repeat (6) @(negedge CLK);
        chk("t1 busy after stop", busy, 1'b0);
        chk("t1 reg3", dut.regs[3], 8'hA5);

        // Random read of 0x03 via repeated START, master NACK
        i2c_start();
        wbyte(8'hE0, ack); chk("t2 addr ack", ack, 1'b1);
        wbyte(8'h03, ack); chk("t2 ptr ack", ack, 1'b1);
        i2c_start();
        wbyte(8'hE1, ack); chk("t2 raddr ack", ack, 1'b1);
        rbyte(rd, 1'b0);   chk("t2 read data", rd, 8'hA5);
        chk("t2 sda released", sda_bus, 1'b1);
        chk("t2 busy", busy, 1'b1);
        i2c_stop();
        repeat (6) @(negedge CLK);
        chk("t2 busy after stop", busy, 1'b0);

        // Foreign address 0x71
        i2c_start();
        wbyte(8'hE2, ack); chk("t3 addr nack", ack, 1'b0);
        chk("t3 busy", busy, 1'b0);
        wbyte(8'h55, ack); chk("t3 data nack", ack, 1'b0);
        i2c_stop();
        repeat (6) @(negedge CLK);

        // Burst across the end of the register file
        i2c_start();
        wbyte(8'hE0, ack); chk("t4 addr ack", ack, 1'b1);
        wbyte(8'h0E, ack); chk("t4 ptr ack", ack, 1'b1);
        expect_wr(8'h0E, 8'h11);
        expect_wr(8'h0F, 8'h22);
        wbyte(8'h11, ack); chk("t4 d0 ack", ack, 1'b1);
        wbyte(8'h22, ack); chk("t4 d1 ack", ack, 1'b1);
        wbyte(8'h33, ack); chk("t4 d2 ack", ack, 1'b1);
        i2c_stop();
        i2c_start();
        wbyte(8'hE0, ack);
        wbyte(8'h0E, ack);
        i2c_start();
        wbyte(8'hE1, ack); chk("t4 raddr ack", ack, 1'b1);
        rbyte(rd, 1'b1);   chk("t4 read 0E", rd, 8'h11);
        rbyte(rd, 1'b0);   chk("t4 read 0F", rd, 8'h22);
        i2c_stop();
        i2c_start();
        wbyte(8'hE0, ack);
        wbyte(8'h10, ack); chk("t4 ptr10 ack", ack, 1'b1);
        i2c_start();
        wbyte(8'hE1, ack);
        rbyte(rd, 1'b0);   chk("t4 read 10", rd, 8'hFF);
        i2c_stop();

        // STOP after 4 data bits, then a complete write
        i2c_start();
        wbyte(8'hE0, ack);
        wbyte(8'h05, ack); chk("t5 ptr ack", ack, 1'b1);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
        i2c_stop();
        repeat (6) @(negedge CLK);
        chk("t5 state idle", 32'(dut.state_q), 32'(S_IDLE));
        chk("t5 busy", busy, 1'b0);
        i2c_start();
        wbyte(8'hE0, ack);
        wbyte(8'h05, ack);
        expect_wr(8'h05, 8'h5A);
        wbyte(8'h5A, ack); chk("t5 data ack", ack, 1'b1);
        i2c_stop();

        // Reset while the target drives a 0 read bit (0x5A, MSB 0)
        i2c_start();
        wbyte(8'hE0, ack);
        wbyte(8'h05, ack);
        i2c_start();
        wbyte(8'hE1, ack); chk("t6 raddr ack", ack, 1'b1);
        chk("t6 target drives 0", sda_bus, 1'b0);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        chk("t6 sda released", sda_bus, 1'b1);
        chk("t6 stb", reg_wr_stb, 1'b0);
        chk("t6 addr", reg_wr_addr, 8'h00);
        chk("t6 data", reg_wr_data, 8'h00);
        chk("t6 busy", busy, 1'b0);
        chk("t6 ptr", dut.ptr_q, 8'h00);
        chk("t6 state idle", 32'(dut.state_q), 32'(S_IDLE));
        chk("t6 reg5 cleared", dut.regs[5], 8'h00);
        @(negedge CLK);
        RST = 1'b0;
        i2c_stop();
        i2c_start();
        wbyte(8'hE0, ack); chk("t6 post addr ack", ack, 1'b1);
        wbyte(8'h01, ack);
        expect_wr(8'h01, 8'h3C);
        wbyte(8'h3C, ack); chk("t6 post data ack", ack, 1'b1);
        i2c_stop();

        repeat (10) @(negedge CLK);
        chk("scoreboard drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/si5338_iic_slave_model.md
# si5338_iic_slave_model

I2C target (responder) holding an 8-bit-addressed register file; the counterpart of the board's I2C master init cores. It answers the same 7-bit slave address as the Si5338 (0x70), so master cores run unchanged against it in system simulation and in hardware loopback, with no real Si5338 attached. It sits on the SCL/SDA pins in place of the device and exposes a write-strobe port so fabric logic can observe register writes.

## Interface
- SLAVE_ADDR, 7'b111_0000, 7-bit address this target ACKs.
- REG_DEPTH, 16, number of implemented registers (pointer values 0..REG_DEPTH-1).
- RD_DEFAULT, 8'hFF, read data returned for unimplemented pointer values.
- CLK  in  1  system clock; only clock domain.
- RST  in  1  synchronous, active-high reset.
- SCL  in  1  I2C clock from master (asynchronous, open-drain line).
- SDA  inout  1  I2C data; driven only to 1'b0, otherwise 1'bz.
- reg_wr_stb  out  1  one-CLK pulse per accepted data byte written.
- reg_wr_addr  out  8  pointer of that write; valid with reg_wr_stb.
- reg_wr_data  out  8  byte written; valid with reg_wr_stb.
- busy  out  1  high from an address-matched START until STOP.

## Operation
- SCL and SDA pass through 2-FF synchronizers plus a previous-sample register. Edges are detected on synchronized values.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. Both are recognised in every state, including mid-byte.
- START (or repeated START) → ADDR. STOP → IDLE, SDA released.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_MACK, IGNORE.
- Bits are sampled on SCL rising edges, MSB first. After 8 bits in ADDR:
  - Upper 7 bits equal SLAVE_ADDR → ADDR_ACK.
  - Otherwise → IGNORE, no ACK, until the next START/STOP.
- ACK slot: pull SDA low on the SCL falling edge that ends bit 8; release it on the next SCL falling edge.
- Write transaction (R/W=0): ADDR_ACK → PTR. The first byte loads the 8-bit pointer, ACKed in PTR_ACK. Each further byte:
  - Goes to WDATA. If pointer < REG_DEPTH, it is stored, reg_wr_stb is pulsed, and the byte is ACKed.
  - If pointer ≥ REG_DEPTH, the byte is still ACKed but not stored, and no strobe is issued.
  - The pointer then increments modulo 256.
- Read transaction (R/W=1): ADDR_ACK → RDATA. The target shifts out reg[ptr], or RD_DEFAULT if out of range.
  - SDA changes only on SCL falling edges. A '1' bit means SDA is released.
  - Master ACK (SDA low at 9th rising edge) → pointer+1, next byte.
  - Master NACK → release SDA, wait in IGNORE for STOP/START.
- The pointer persists across transactions. Repeated START with R/W=1 after a pointer write is the standard random-read sequence.
- Register file resets to 8'h00.

## Timing
- CLK ≥ 16× SCL frequency (50 MHz vs 250 kHz in the current system).
- Line-to-decision latency: 3 CLK (2 sync + edge register). Drive changes appear at SDA 1 CLK after the detected SCL falling edge, well inside tHD;DAT.
- reg_wr_stb is asserted the CLK after the 8th data-bit rising edge, for exactly 1 CLK.
- Reset values: SDA released (z), reg_wr_stb=0, reg_wr_addr=0, reg_wr_data=0, busy=0, state IDLE, pointer 0.
- RST mid-transfer releases SDA on the next CLK. The bus is then ignored until a fresh START.
- START/STOP mid-byte discards the partial byte; no strobe is issued.
- Simultaneous SCL and SDA change within one sample is treated as a data change, not START/STOP.

## Structure
- Package si5338_iic_pkg: FSM state encoding, the ACK/NACK constants, and the default 0x70 address, shared with the master-side cores' testbenches.
- Sub-module iic_line_sync: 2-FF synchronizer and rise/fall detect, instantiated once each for SCL and SDA.
- Register file stays inline as a REG_DEPTH×8 array.

## Test plan
- Master writes ptr 0x03, data 0xA5 → ACK on all 3 bytes; reg_wr_stb once with addr 0x03, data 0xA5; reg[3]=0xA5.
- Write ptr 0x03 then repeated START, read 1 byte with NACK → SDA carries 0xA5; target releases SDA; busy falls at STOP.
- Address 0x71 sent → no ACK (SDA high at 9th clock), no strobes, busy stays 0.
- Burst write ptr 0x0E, data 0x11,0x22,0x33 (REG_DEPTH=16) → strobes at 0x0E and 0x0F only; third byte ACKed; readback of ptr 0x10 gives 0xFF.
- STOP injected after 4 data bits → no strobe; FSM IDLE; next full write succeeds.
- RST asserted while target drives a 0 read bit → SDA z next CLK; outputs at reset values; pointer 0.
